lpe_column_result_collector: RTL and testbench

- Sits below the bottom processing element of one systolic column and consumes that column's down stream.
- Extracts result words tagged with the result user mask and stores them by row index from tuser.
- Once all PE_NUMBER_J results of a tile have arrived, replays them in row order 0..PE_NUMBER_J-1 as one framed AXI-Stream packet toward the output interconnect.
- Drops and flags stray operand words, duplicates and framing violations.

---
 rtl/lpe_column_result_collector_pkg.sv | 30 +++
 rtl/lpe_column_result_collector_if.sv | 25 ++
 rtl/lpe_column_result_collector.sv | 184 ++++++++++++++++++
 tb/tb_lpe_column_result_collector.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/lpe_column_result_collector_pkg.sv
// Shared constants, state type and helper functions for the column result collector,
// the processing element and its control unit (keeps tuser masks in one place).
package lpe_column_result_collector_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 32'd0;
    v   = value - 32'd1;
    while (v > 32'd0) begin
      res = res + 32'd1;
      v   = v >> 32'd1;
    end
    return res;
  endfunction

  function automatic int unsigned rslt_user_mask(input int user_width);
    return 32'd1 << (user_width - 32'd1);
  endfunction

  function automatic int unsigned op1_user_mask(input int user_width);
    return 32'd1 << (user_width - 32'd2);
  endfunction

endpackage

// File: rtl/lpe_column_result_collector_if.sv
// AXI-Stream style bundle used on both the input (down stream) and output sides.
interface lpe_column_result_collector_if #(
  parameter int DATA_W = 16,
  parameter int USER_W = 8,
  parameter int DEST_W = 4,
  parameter int ID_W   = 4
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [USER_W-1:0] tuser;
  logic [DEST_W-1:0] tdest;
  logic [ID_W-1:0]   tid;

  modport master (
    output tdata, tvalid, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/lpe_column_result_collector.sv
// Collects tagged results from the bottom of a systolic column and replays them
// in row order as one framed stream packet; flags stray, duplicate and framing errors.
module lpe_column_result_collector
  import lpe_column_result_collector_pkg::*;
#(
  parameter int PE_NUMBER_J = 4,
  parameter int U_D_WIDTH   = 16,
  parameter int RSLT_WIDTH  = 16,
  parameter int USER_WIDTH  = 8,
  parameter logic [USER_WIDTH-1:0] RSLT_USER_MASK = USER_WIDTH'(rslt_user_mask(USER_WIDTH)),
  parameter logic [USER_WIDTH-1:0] OP1_USER_MASK  = USER_WIDTH'(op1_user_mask(USER_WIDTH)),
  parameter int DEST_WIDTH  = 4,
  parameter int ID_WIDTH    = 4,
  parameter logic [DEST_WIDTH-1:0] OUTPUT_DEST = DEST_WIDTH'(1),
  parameter logic [ID_WIDTH-1:0]   OUTPUT_ID   = ID_WIDTH'(1)
) (
  input  logic clk,
  input  logic rst_n,
  lpe_column_result_collector_if.slave  s_axis,
  lpe_column_result_collector_if.master m_axis,
  output logic frame_done,
  output logic err_stray,
  output logic err_index,
  output logic err_dup,
  output logic err_last
);

  localparam int IDX_W = (clog2(PE_NUMBER_J) > 1) ? clog2(PE_NUMBER_J) : 1;

  state_e                  state_r, state_nxt;
  logic [PE_NUMBER_J-1:0]  bitmap_r, bitmap_nxt;
  logic [IDX_W-1:0]        cnt_r, cnt_nxt;
  logic [RSLT_WIDTH-1:0]   buf_r   [PE_NUMBER_J];
  logic [RSLT_WIDTH-1:0]   buf_nxt [PE_NUMBER_J];

  logic                    ready_r;
  logic                    m_valid_r;
  logic [RSLT_WIDTH-1:0]   m_data_r;
  logic [IDX_W-1:0]        m_user_r;
  logic                    m_last_r;
  logic                    done_r, done_nxt;
  logic                    stray_r, stray_nxt;
  logic                    index_r, index_nxt;
  logic                    dup_r, dup_nxt;
  logic                    last_r, last_nxt;

  logic                    accept_s;
  logic                    is_rslt_s;
  logic [IDX_W-1:0]        idx_s;
  logic [PE_NUMBER_J-1:0]  onehot_s;
  logic                    idx_ok_s;
  logic                    last_row_s;
  logic [RSLT_WIDTH-1:0]   rslt_s;

  // Only the low result bits, the row index field and the result mask bit matter here.
  wire unused_ok_s = &{1'b0, s_axis.tuser, s_axis.tdata, OP1_USER_MASK};

  assign accept_s   = s_axis.tvalid & ready_r;
  assign is_rslt_s  = |(s_axis.tuser & RSLT_USER_MASK);
  assign idx_s      = s_axis.tuser[IDX_W-1:0];
  assign rslt_s     = s_axis.tdata[RSLT_WIDTH-1:0];
  assign idx_ok_s   = |onehot_s;
  assign last_row_s = (cnt_r == IDX_W'(PE_NUMBER_J - 1));

  // Decode the incoming row index; indices past the last row decode to all-zero.
  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < PE_NUMBER_J; i++) begin
      onehot_s[i] = (idx_s == IDX_W'(i));
    end
  end

  // Next-state logic: collect into the buffer, then drain it row by row.
  always_comb begin
    state_nxt  = state_r;
    bitmap_nxt = bitmap_r;
    cnt_nxt    = cnt_r;
    buf_nxt    = buf_r;
    done_nxt   = 1'b0;
    stray_nxt  = 1'b0;
    index_nxt  = 1'b0;
    dup_nxt    = 1'b0;
    last_nxt   = 1'b0;
    case (state_r)
      COLLECT: begin
        if (accept_s) begin
          if (!is_rslt_s) begin
            stray_nxt = 1'b1;
          end else if (!idx_ok_s) begin
            index_nxt = 1'b1;
          end else if (|(bitmap_r & onehot_s)) begin
            dup_nxt = 1'b1;
          end else begin
            bitmap_nxt = bitmap_r | onehot_s;
            for (int i = 0; i < PE_NUMBER_J; i++) begin
              buf_nxt[i] = onehot_s[i] ? rslt_s : buf_r[i];
            end
            last_nxt = s_axis.tlast ^ onehot_s[PE_NUMBER_J-1];
          end
        end else begin
          bitmap_nxt = bitmap_r;
        end
        // The completing beat hands over straight to the drain phase.
        if (&bitmap_nxt) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
        end else begin
          state_nxt = COLLECT;
        end
      end
      DRAIN: begin
        if (m_axis.tready) begin
          if (last_row_s) begin
            state_nxt  = COLLECT;
            bitmap_nxt = '0;
            cnt_nxt    = '0;
            done_nxt   = 1'b1;
          end else begin
            cnt_nxt = cnt_r + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt_r;
        end
      end
      default: begin
        state_nxt  = COLLECT;
        bitmap_nxt = '0;
        cnt_nxt    = '0;
      end
    endcase
  end

  // Control state, output stage and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= COLLECT;
      bitmap_r  <= '0;
      cnt_r     <= '0;
      ready_r   <= 1'b0;
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_user_r  <= '0;
      m_last_r  <= 1'b0;
      done_r    <= 1'b0;
      stray_r   <= 1'b0;
      index_r   <= 1'b0;
      dup_r     <= 1'b0;
      last_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt;
      bitmap_r  <= bitmap_nxt;
      cnt_r     <= cnt_nxt;
      ready_r   <= (state_nxt == COLLECT);
      m_valid_r <= (state_nxt == DRAIN);
      m_data_r  <= (state_nxt == DRAIN) ? buf_nxt[cnt_nxt] : '0;
      m_user_r  <= (state_nxt == DRAIN) ? cnt_nxt : '0;
      m_last_r  <= (state_nxt == DRAIN) && (cnt_nxt == IDX_W'(PE_NUMBER_J - 1));
      done_r    <= done_nxt;
      stray_r   <= stray_nxt;
      index_r   <= index_nxt;
      dup_r     <= dup_nxt;
      last_r    <= last_nxt;
    end
  end

  // Result storage; contents are only meaningful where the bitmap is set.
  always_ff @(posedge clk) begin
    buf_r <= buf_nxt;
  end

  assign s_axis.tready = ready_r;
  assign m_axis.tvalid = m_valid_r;
  assign m_axis.tdata  = m_data_r;
  assign m_axis.tuser  = m_user_r;
  assign m_axis.tlast  = m_last_r;
  assign m_axis.tdest  = OUTPUT_DEST;
  assign m_axis.tid    = OUTPUT_ID;
  assign frame_done    = done_r;
  assign err_stray     = stray_r;
  assign err_index     = index_r;
  assign err_dup       = dup_r;
  assign err_last      = last_r;

endmodule

// File: tb/tb_lpe_column_result_collector.sv
// Directed self-checking bench for lpe_column_result_collector (PE_NUMBER_J = 4).
module tb_lpe_column_result_collector;

  logic clk;
  logic rst_n;
  logic frame_done, err_stray, err_index, err_dup, err_last;
  int   n_cmp;
  int   n_err;

  lpe_column_result_collector_if #(.DATA_W(16), .USER_W(8), .DEST_W(4), .ID_W(4)) s_axis_if ();
  lpe_column_result_collector_if #(.DATA_W(16), .USER_W(2), .DEST_W(4), .ID_W(4)) m_axis_if ();

  lpe_column_result_collector #(
    .PE_NUMBER_J(4), .U_D_WIDTH(16), .RSLT_WIDTH(16), .USER_WIDTH(8),
    .DEST_WIDTH(4), .ID_WIDTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axis     (s_axis_if),
    .m_axis     (m_axis_if),
    .frame_done (frame_done),
    .err_stray  (err_stray),
    .err_index  (err_index),
    .err_dup    (err_dup),
    .err_last   (err_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: presents one beat, returns on the next falling edge.
  task automatic send(input logic [7:0] user, input logic [15:0] data,
                      input logic last, input logic [3:0] exp_err);
    chk("s_tready_collect", s_axis_if.tready, 32'd1);
    s_axis_if.tvalid = 1'b1;
    s_axis_if.tuser  = user;
    s_axis_if.tdata  = data;
    s_axis_if.tlast  = last;
    @(negedge clk);
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tlast  = 1'b0;
    chk("err_vec", {err_stray, err_index, err_dup, err_last}, exp_err);
  endtask

  // Expects a drain to be in progress; toggle=1 applies m_tready 1,0,1,0...
  task automatic drain(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3, input bit toggle);
    logic [15:0] exp_d [4];
    int row;
    int cyc;
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    row = 0;
    cyc = 0;
    while (row < 4 && cyc < 20) begin
      m_axis_if.tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      chk("m_tvalid", m_axis_if.tvalid, 32'd1);
      chk("m_tdata", m_axis_if.tdata, exp_d[row]);
      chk("m_tuser", m_axis_if.tuser, row);
      chk("m_tlast", m_axis_if.tlast, (row == 3) ? 32'd1 : 32'd0);
      chk("s_tready_drain", s_axis_if.tready, 32'd0);
      chk("frame_done_early", frame_done, 32'd0);
      @(negedge clk);
      if (m_axis_if.tready) row++;
      cyc++;
    end
    chk("drain_rows", row, 32'd4);
    chk("drain_cycles", cyc, toggle ? 32'd7 : 32'd4);
    chk("frame_done", frame_done, 32'd1);
    chk("m_tvalid_after", m_axis_if.tvalid, 32'd0);
    chk("s_tready_after", s_axis_if.tready, 32'd1);
    m_axis_if.tready = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    s_axis_if.tvalid = 1'b0;
    s_axis_if.tdata  = 16'h0000;
    s_axis_if.tuser  = 8'h00;
    s_axis_if.tlast  = 1'b0;
    s_axis_if.tdest  = 4'h0;
    s_axis_if.tid    = 4'h0;
    m_axis_if.tready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_s_tready", s_axis_if.tready, 32'd0);
    chk("rst_m_tvalid", m_axis_if.tvalid, 32'd0);
    chk("rst_m_tlast", m_axis_if.tlast, 32'd0);
    chk("rst_m_tdata", m_axis_if.tdata, 32'd0);
    chk("rst_m_tuser", m_axis_if.tuser, 32'd0);
    chk("rst_flags", {frame_done, err_stray, err_index, err_dup, err_last}, 32'd0);
    chk("m_tdest", m_axis_if.tdest, 32'd1);
    chk("m_tid", m_axis_if.tid, 32'd1);

    rst_n = 1'b1;
    @(negedge clk);

    // Reverse-order results, output drained with tready held high
    send(8'h83, 16'h0A03, 1'b1, 4'b0000);
    send(8'h82, 16'h0A02, 1'b0, 4'b0000);
    send(8'h81, 16'h0A01, 1'b0, 4'b0000);
    send(8'h80, 16'h0A00, 1'b0, 4'b0000);
    drain(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 1'b0);

    // Same frame with backpressure on the output
    send(8'h83, 16'h0A03, 1'b1, 4'b0000);
    send(8'h82, 16'h0A02, 1'b0, 4'b0000);
    send(8'h81, 16'h0A01, 1'b0, 4'b0000);
    send(8'h80, 16'h0A00, 1'b0, 4'b0000);
    drain(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 1'b1);

    // Weight word and an untagged word mid-frame are dropped
    send(8'h80, 16'h0A00, 1'b0, 4'b0000);
    send(8'h81, 16'h0A01, 1'b0, 4'b0000);
    send(8'h40, 16'hDEAD, 1'b0, 4'b1000);
    send(8'h00, 16'hBEEF, 1'b1, 4'b1000);
    send(8'h82, 16'h0A02, 1'b0, 4'b0000);
    send(8'h83, 16'h0A03, 1'b1, 4'b0000);
    drain(16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 1'b0);

    // Duplicate row 1 keeps the first value
    send(8'h80, 16'h3000, 1'b0, 4'b0000);
    send(8'h81, 16'h1111, 1'b0, 4'b0000);
    send(8'h81, 16'h2222, 1'b0, 4'b0010);
    send(8'h82, 16'h3002, 1'b0, 4'b0000);
    send(8'h83, 16'h3003, 1'b1, 4'b0000);
    drain(16'h3000, 16'h1111, 16'h3002, 16'h3003, 1'b0);

    // tlast on a middle row is flagged but the value is still stored
    send(8'h80, 16'h4000, 1'b0, 4'b0000);
    send(8'h82, 16'h4002, 1'b1, 4'b0001);
    send(8'h81, 16'h4001, 1'b0, 4'b0000);
    send(8'h83, 16'h4003, 1'b1, 4'b0000);
    drain(16'h4000, 16'h4001, 16'h4002, 16'h4003, 1'b0);

    // Missing tlast on the last row, scrambled arrival order
    send(8'h81, 16'h5001, 1'b0, 4'b0000);
    send(8'h83, 16'h5003, 1'b0, 4'b0001);
    send(8'h80, 16'h5000, 1'b0, 4'b0000);
    send(8'h82, 16'h5002, 1'b0, 4'b0000);
    drain(16'h5000, 16'h5001, 16'h5002, 16'h5003, 1'b0);

    // Reset asserted in the middle of a drain
    send(8'h80, 16'h0B00, 1'b0, 4'b0000);
    send(8'h81, 16'h0B01, 1'b0, 4'b0000);
    send(8'h82, 16'h0B02, 1'b0, 4'b0000);
    send(8'h83, 16'h0B03, 1'b1, 4'b0000);
    chk("mid_row0", m_axis_if.tdata, 32'h0B00);
    @(negedge clk);
    chk("mid_row1", m_axis_if.tdata, 32'h0B01);
    @(negedge clk);
    chk("mid_row2", m_axis_if.tdata, 32'h0B02);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_tvalid", m_axis_if.tvalid, 32'd0);
    chk("arst_m_tdata", m_axis_if.tdata, 32'd0);
    chk("arst_m_tlast", m_axis_if.tlast, 32'd0);
    chk("arst_s_tready", s_axis_if.tready, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", {frame_done, err_stray, err_index, err_dup, err_last}, 32'd0);
    send(8'h82, 16'h0C02, 1'b0, 4'b0000);
    chk("post_rst_no_drain", m_axis_if.tvalid, 32'd0);
    send(8'h80, 16'h0C00, 1'b0, 4'b0000);
    send(8'h83, 16'h0C03, 1'b1, 4'b0000);
    chk("post_rst_still_collect", m_axis_if.tvalid, 32'd0);
    send(8'h81, 16'h0C01, 1'b0, 4'b0000);
    drain(16'h0C00, 16'h0C01, 16'h0C02, 16'h0C03, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
